// File: rtl/fir_coeff_tx_if.sv
// ============================================================================
// Module : fir_coeff_tx_if
// Brief  : Host-side valid/ready word port of the FIR coefficient transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fir_coeff_tx_if #(
    parameter int BITS = 8
) ();
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/fir_coeff_tx.sv
// ============================================================================
// Module : fir_coeff_tx
// Brief  : FIFO-buffered parallel-to-serial loader for bit-serial FIR taps.
//          Define FIR_COEFF_TX_LSB_FIRST_EN to serialize LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fir_coeff_tx #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    fir_coeff_tx_if.slave                 bus,
    output logic                          coeff_load_out,
    output logic                          coeff_out,
    output logic                          word_done,
    output logic                          busy,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [BITS-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [BITS-1:0]     r_shreg;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_load;
    logic                r_word_done;

    logic                w_full;
    logic                w_nonempty;
    logic                w_push;
    logic                w_pop;
    logic [BITS-1:0]     w_head;
    logic [BITS-1:0]     w_shreg_next;
    logic                w_serial_bit;

    assign w_full     = (r_level == c_LVL_W'(DEPTH));
    assign w_nonempty = (r_level != '0);
    assign w_push     = bus.in_valid && !w_full;
    // The FSM takes the head either from IDLE or on the last gap cycle.
    assign w_pop      = w_nonempty &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == c_GAP_W'(GAP - 1))));
    assign w_head     = r_mem[r_rd_ptr];

`ifdef FIR_COEFF_TX_LSB_FIRST_EN
    assign w_shreg_next = {1'b0, r_shreg[BITS-1:1]};
    assign w_serial_bit = r_shreg[0];
`else
    assign w_shreg_next = {r_shreg[BITS-2:0], 1'b0};
    assign w_serial_bit = r_shreg[BITS-1];
`endif

    assign bus.in_ready   = !w_full;
    assign coeff_load_out = r_load;
    // The shift register drains to zero during SEND, so the line idles low.
    assign coeff_out      = w_serial_bit;
    assign word_done      = r_word_done;
    assign busy           = (r_state != ST_IDLE) || w_nonempty;
    assign level          = r_level;

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_load      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shreg   <= w_head;
                        r_bit_cnt <= '0;
                        r_load    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_shreg   <= w_shreg_next;
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                    if (r_bit_cnt == c_BIT_W'(BITS - 1)) begin
                        r_gap_cnt   <= '0;
                        r_load      <= 1'b0;
                        r_word_done <= 1'b1;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_W'(GAP - 1)) begin
                        if (w_pop) begin
                            r_shreg   <= w_head;
                            r_bit_cnt <= '0;
                            r_load    <= 1'b1;
                            r_state   <= ST_SEND;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_tx.sv
// ============================================================================
// Module : tb_fir_coeff_tx
// Brief  : Directed self-checking bench for fir_coeff_tx (BITS=8, DEPTH=4, GAP=1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fir_coeff_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coeff_load_out;
    logic       coeff_out;
    logic       word_done;
    logic       busy;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;

    logic [7:0] fw [6];

    fir_coeff_tx_if #(.BITS(8)) bus ();

    fir_coeff_tx #(
        .BITS  (8),
        .DEPTH (4),
        .GAP   (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .coeff_load_out (coeff_load_out),
        .coeff_out      (coeff_out),
        .word_done      (word_done),
        .busy           (busy),
        .level          (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit sent at serial position i of word w.
    function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef FIR_COEFF_TX_LSB_FIRST_EN
        return w[i];
`else
        return w[7 - i];
`endif
    endfunction

    task automatic check_bits(input logic [7:0] w, input int from, input int to, input string tag);
        for (int i = from; i <= to; i++) begin
            check($sformatf("%s_load%0d", tag, i), {31'd0, coeff_load_out}, 32'd1);
            check($sformatf("%s_bit%0d", tag, i), {31'd0, coeff_out}, {31'd0, exp_bit(w, i)});
            tick();
        end
    endtask

    task automatic check_gap(input string tag);
        check({tag, "_gap_load"}, {31'd0, coeff_load_out}, 32'd0);
        check({tag, "_gap_done"}, {31'd0, word_done}, 32'd1);
        check({tag, "_gap_data"}, {31'd0, coeff_out}, 32'd0);
        tick();
    endtask

    initial begin
        fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
        fw[3] = 8'h44; fw[4] = 8'h55; fw[5] = 8'h66;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset held for two cycles
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_load",  {31'd0, coeff_load_out}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, word_done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_load",  {31'd0, coeff_load_out}, 32'd0);
        check("post_rst_level", {29'd0, level}, 32'd0);

        // Single word 0xA5
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        check("single_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("single_level_c1", {29'd0, level}, 32'd1);
        check("single_load_c1",  {31'd0, coeff_load_out}, 32'd0);
        check("single_busy_c1",  {31'd0, busy}, 32'd1);
        tick();
        check_bits(8'hA5, 0, 7, "single");
        check_gap("single");
        check("single_busy_end",  {31'd0, busy}, 32'd0);
        check("single_done_end",  {31'd0, word_done}, 32'd0);
        check("single_level_end", {29'd0, level}, 32'd0);
        tick();
        tick();

        // Back-to-back pushes in cycles 0..3
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        tick();
        bus.in_data  = 8'h80;
        check("b2b_load_c1", {31'd0, coeff_load_out}, 32'd0);
        tick();
        bus.in_data  = 8'hFF;
        check_bits(8'h01, 0, 0, "b2b_w0");
        bus.in_data  = 8'h3C;
        check_bits(8'h01, 1, 1, "b2b_w0");
        bus.in_valid = 1'b0;
        check("b2b_level_c4", {29'd0, level}, 32'd3);
        check_bits(8'h01, 2, 7, "b2b_w0");
        check_gap("b2b_w0");
        check_bits(8'h80, 0, 7, "b2b_w1");
        check_gap("b2b_w1");
        check_bits(8'hFF, 0, 7, "b2b_w2");
        check_gap("b2b_w2");
        check_bits(8'h3C, 0, 7, "b2b_w3");
        check_gap("b2b_w3");
        check("b2b_busy_end",  {31'd0, busy}, 32'd0);
        check("b2b_level_end", {29'd0, level}, 32'd0);
        tick();
        tick();

        // Full FIFO: six words offered continuously
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fw[k];
            check($sformatf("full_ready_c%0d", k), {31'd0, bus.in_ready}, 32'd1);
            tick();
        end
        bus.in_data = fw[5];
        check("full_level_c5", {29'd0, level}, 32'd4);
        check("full_ready_c5", {31'd0, bus.in_ready}, 32'd0);
        check_bits(fw[0], 3, 7, "full_w0");
        check("full_ready_c10", {31'd0, bus.in_ready}, 32'd0);
        check_gap("full_w0");
        check("full_ready_c11", {31'd0, bus.in_ready}, 32'd1);
        check("full_level_c11", {29'd0, level}, 32'd3);
        check_bits(fw[1], 0, 0, "full_w1");
        bus.in_valid = 1'b0;
        check("full_level_c12", {29'd0, level}, 32'd4);
        check_bits(fw[1], 1, 7, "full_w1");
        check_gap("full_w1");
        for (int k = 2; k < 6; k++) begin
            check_bits(fw[k], 0, 7, $sformatf("full_w%0d", k));
            check_gap($sformatf("full_w%0d", k));
        end
        check("full_busy_end",  {31'd0, busy}, 32'd0);
        check("full_level_end", {29'd0, level}, 32'd0);
        tick();
        tick();

        // Reset during the 4th bit of the first burst; a push offered in reset is ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        tick();
        bus.in_data  = 8'h0F;
        tick();
        bus.in_valid = 1'b0;
        check_bits(8'hFF, 0, 2, "rstmid");
        check("rstmid_load_bit3", {31'd0, coeff_load_out}, 32'd1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check("rstmid_load",  {31'd0, coeff_load_out}, 32'd0);
        check("rstmid_data",  {31'd0, coeff_out}, 32'd0);
        check("rstmid_level", {29'd0, level}, 32'd0);
        check("rstmid_busy",  {31'd0, busy}, 32'd0);
        check("rstmid_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rstmid_done",  {31'd0, word_done}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("rstmid_quiet_load%0d", k), {31'd0, coeff_load_out}, 32'd0);
            check($sformatf("rstmid_quiet_busy%0d", k), {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_coeff_tx.md
Name: fir_coeff_tx

Overview:
- Transmit side of the FIR serial coefficient-load interface.
- Accepts parallel coefficient words on a valid/ready port and buffers them in a small FIFO.
- Serializes each word onto the coeff_load/coeff_data pair that the bit-serial FIR consumes.
- Sits between the host/config logic and one or more FIR instances; the FIR shifts coeff_data in once per cycle while coeff_load is high.

Parameters:
- BITS, 8: coefficient word width; equals the FIR's BITS.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- GAP, 1: low cycles on coeff_load_out between consecutive words; at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  host presents a word
- in_ready  out  1  FIFO can accept a word
- in_data  in  BITS  coefficient word
- coeff_load_out  out  1  serial-load strobe, drives the FIR coeff_load_in
- coeff_out  out  1  serial data bit, drives the FIR coeff_in
- word_done  out  1  one-cycle pulse after the last bit of a word
- busy  out  1  FIFO non-empty or a word in flight
- level  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the word in the shift register)

Behaviour:
- Interface (already decided): reset rst_n, synchronous, active-low; clock clk.
- Reset values: coeff_load_out=0, coeff_out=0, word_done=0, busy=0, level=0, in_ready=1. FIFO pointers, shift register, bit counter and gap counter all cleared.
- Push: in_valid && in_ready at a rising edge writes in_data to the FIFO tail.
- in_ready = !full, combinational from registered occupancy. No push while full; the host holds in_data/in_valid stable until accepted.
- No fall-through: a word pushed in cycle t becomes visible to the FSM in cycle t+1.
- Simultaneous push and pop: allowed at any level except full (no push) and empty (no pop). Level is unchanged.
- FSM states IDLE, SEND, GAP; state and all datapath registers are flopped.
- IDLE:
  - If level != 0: pop the head into shift register shreg, bit_cnt=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - coeff_load_out=1 and coeff_out=shreg[BITS-1] (MSB first).
  - Each cycle: shift shreg left by 1, increment bit_cnt.
  - When bit_cnt==BITS-1: go to GAP, gap_cnt=0.
  - SEND lasts exactly BITS cycles.
- GAP:
  - coeff_load_out=0, coeff_out=0.
  - word_done=1 in the first GAP cycle only.
  - When gap_cnt==GAP-1: if level != 0, pop and go directly to SEND; otherwise go to IDLE.
  - The low time between bursts is exactly GAP cycles.
- Latency: push at cycle t gives the first coeff_load_out high at cycle t+2 when the FSM is in IDLE.
- busy = (state!=IDLE) || (level!=0).
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- coeff_load_out is never high for fewer or more than BITS consecutive cycles.
- Reset mid-word: on the synchronous reset edge the partial word is abandoned and FIFO contents are discarded. coeff_load_out=0 from the next cycle. The downstream FIR holds a partial coefficient; the host must reload it.
- in_valid is ignored while rst_n=0.

Optional Feature:
- Macro FIR_COEFF_TX_LSB_FIRST_EN.
- Defined: coeff_out=shreg[0] and shreg shifts right, so the LSB is sent first. This is for receivers that shift from the MSB end.
- Undefined: MSB first, as described above.
- Timing, word_done and the FIFO are identical in both modes.

Test Plan (BITS=8, DEPTH=4, GAP=1):
- Reset: hold rst_n=0 for 2 cycles, then release -> coeff_load_out=0, in_ready=1, level=0, busy=0, word_done=0.
- Single word: push 0xA5 at cycle 0 ->
  - coeff_load_out high in cycles 2..9 with coeff_out=1,0,1,0,0,1,0,1;
  - word_done=1 in cycle 10 only;
  - busy=0 from cycle 11.
- Back-to-back: push 0x01, 0x80, 0xFF, 0x3C in cycles 0..3 -> four 8-cycle bursts starting at cycles 2, 11, 20, 29, each separated by exactly 1 low cycle, with bit patterns matching MSB-first.
- Full FIFO: in_valid high with 6 distinct words from cycle 0 ->
  - words 1..5 accepted in cycles 0..4; level=4 and in_ready=0 in cycle 5;
  - word 6 accepted in cycle 11 after the pop at the end of cycle 10;
  - all 6 words emitted in push order.
- Reset mid-word: push 0xFF and 0x0F, drop rst_n during the 4th bit of the first burst -> coeff_load_out=0 next cycle, level=0, no further bursts after rst_n=1.
- FIR_COEFF_TX_LSB_FIRST_EN defined: push 0x01 -> coeff_out=1,0,0,0,0,0,0,0. Without the macro: 0,0,0,0,0,0,0,1.
